// File: rtl/commit_trace_buf.sv
// Retirement trace buffer: captures retired-instruction records into a FIFO,
// drains them on a valid/ready stream, and tracks instret and overflow drops.
module commit_trace_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_instr,
  input  logic [4:0]  ret_rd,
  input  logic        ret_wen,
  input  logic [31:0] ret_wdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_wdata,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        full,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [31:0] instret
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
  } entry_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        new_entry;
  entry_t        head;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;

  logic push_try;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    new_entry       = '0;
    new_entry.pc    = ret_pc;
    new_entry.instr = ret_instr;
    new_entry.rd    = ret_rd;
    // Writes to x0 are architecturally void; the trace reports them as no-write.
    new_entry.wen   = ret_wen & (ret_rd != 5'd0);
    new_entry.wdata = ret_wdata;
  end

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_CNT);

  assign push_try = ret_valid & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = push_try & (~full | pop);
  assign drop     = push_try & ~push_ok;

  assign head      = mem[rp];
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_rd    = head.rd;
  assign out_wen   = head.wen;
  assign out_wdata = head.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (push_ok) begin
      mem[wp] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Every retirement counts, including ones presented during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (ret_valid) begin
      instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed self-checking bench for commit_trace_buf: FIFO order, x0 normalisation,
// overflow/drop accounting, full push+pop, streaming wrap, flush and async reset.
module tb_commit_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic [4:0]  ret_rd;
  logic        ret_wen;
  logic [31:0] ret_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        full;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [31:0] instret;

  int checks = 0;
  int fails  = 0;

  commit_trace_buf #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd(ret_rd), .ret_wen(ret_wen), .ret_wdata(ret_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_wen(out_wen),
    .full(full), .overflow(overflow), .drop_cnt(drop_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wen, input logic [31:0] wd);
    ret_valid = v;
    ret_pc    = pc;
    ret_instr = pc + 32'h1000_0000;
    ret_rd    = rd;
    ret_wen   = wen;
    ret_wdata = wd;
  endtask

  task automatic do_reset();
    set_ret(1'b0, '0, '0, 1'b0, '0);
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #13;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (drop_cnt !== 16'h0) begin fails++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
    checks++; if (instret !== 32'h0) begin fails++; $display("FAIL reset_instret got %h exp 0", instret); end
    checks++; if ({out_pc, out_instr, out_wdata, out_rd, out_wen} !== '0) begin
      fails++; $display("FAIL reset_fields got %h %h %h %h %b exp 0", out_pc, out_instr, out_wdata, out_rd, out_wen);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      set_ret(1'b1, 32'(i * 4), 5'(i + 1), 1'b1, 32'(8'h11 * (i + 1)));
      step();
    end
    ret_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL basic_head_pc got %h exp 0", out_pc); end
    checks++; if (out_rd !== 5'd1) begin fails++; $display("FAIL basic_head_rd got %0d exp 1", out_rd); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_pc !== 32'(i * 4)) begin fails++; $display("FAIL basic_pop_pc[%0d] got %h exp %h", i, out_pc, i * 4); end
      checks++; if (out_wdata !== 32'(8'h11 * (i + 1))) begin fails++; $display("FAIL basic_pop_wdata[%0d] got %h exp %h", i, out_wdata, 8'h11 * (i + 1)); end
      checks++; if (out_instr !== 32'(i * 4) + 32'h1000_0000) begin fails++; $display("FAIL basic_pop_instr[%0d] got %h", i, out_instr); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_empty got %b exp 0", out_valid); end
    checks++; if (instret !== 32'd3) begin fails++; $display("FAIL basic_instret got %0d exp 3", instret); end
    checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL basic_drop got %0d exp 0", drop_cnt); end
    // Pops requested on an empty FIFO must not underflow the count.
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_pop_valid got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_x0();
    set_ret(1'b1, 32'h40, 5'd0, 1'b1, 32'hDEAD_BEEF);
    step();
    set_ret(1'b1, 32'h44, 5'd7, 1'b1, 32'h77);
    step();
    ret_valid = 1'b0;
    checks++; if (out_wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %b exp 0", out_wen); end
    checks++; if (out_rd !== 5'd0) begin fails++; $display("FAIL x0_rd got %0d exp 0", out_rd); end
    checks++; if (out_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL x0_wdata got %h exp deadbeef", out_wdata); end
    out_ready = 1'b1;
    step();
    checks++; if (out_wen !== 1'b1) begin fails++; $display("FAIL rd7_wen got %b exp 1", out_wen); end
    checks++; if (out_rd !== 5'd7) begin fails++; $display("FAIL rd7_rd got %0d exp 7", out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL x0_drain got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_ret(1'b1, 32'(i * 4), 5'(i + 1), 1'b1, 32'(i));
      step();
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL ovf_full15 got %b exp 0", full); end
      end
      if (i == 15) begin
        checks++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full16 got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b exp 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL ovf_drop16 got %0d exp 0", drop_cnt); end
      end
    end
    ret_valid = 1'b0;
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", full); end
    checks++; if (drop_cnt !== 16'd4) begin fails++; $display("FAIL ovf_drop got %0d exp 4", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (instret !== 32'd20) begin fails++; $display("FAIL ovf_instret got %0d exp 20", instret); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL ovf_head got %h exp 0", out_pc); end
  endtask

  task automatic test_full_push_pop();
    set_ret(1'b1, 32'h500, 5'd9, 1'b1, 32'h55);
    out_ready = 1'b1;
    step();
    ret_valid = 1'b0;
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL fpp_full got %b exp 1", full); end
    checks++; if (drop_cnt !== 16'd4) begin fails++; $display("FAIL fpp_drop got %0d exp 4", drop_cnt); end
    checks++; if (instret !== 32'd21) begin fails++; $display("FAIL fpp_instret got %0d exp 21", instret); end
    for (int j = 1; j < 16; j++) begin
      checks++; if (out_pc !== 32'(j * 4)) begin fails++; $display("FAIL fpp_order[%0d] got %h exp %h", j, out_pc, j * 4); end
      step();
    end
    checks++; if (out_pc !== 32'h500) begin fails++; $display("FAIL fpp_new_pc got %h exp 500", out_pc); end
    checks++; if (out_rd !== 5'd9) begin fails++; $display("FAIL fpp_new_rd got %0d exp 9", out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fpp_empty got %b exp 0", out_valid); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL fpp_notfull got %b exp 0", full); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_ret(1'b1, 32'h100 + 32'(i * 4), 5'(i % 31 + 1), 1'b1, 32'(i));
      step();
      // Head always equals the entry just pushed, so count never exceeds 1.
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_pc !== 32'h100 + 32'(i * 4)) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 32'h100 + i * 4); end
      checks++; if (out_wdata !== 32'(i)) begin fails++; $display("FAIL stream_wdata[%0d] got %h exp %h", i, out_wdata, i); end
    end
    ret_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end got %b exp 0", out_valid); end
    checks++; if (instret !== 32'd40) begin fails++; $display("FAIL stream_instret got %0d exp 40", instret); end
    checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL stream_drop got %0d exp 0", drop_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_ret(1'b1, 32'h200 + 32'(i * 4), 5'd3, 1'b1, 32'(i));
      step();
    end
    ret_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fl_pre_ovf got %b exp 1", overflow); end
    out_ready = 1'b1;
    repeat (11) step();
    out_ready = 1'b0;
    checks++; if (out_pc !== 32'h22C) begin fails++; $display("FAIL fl_pre_head got %h exp 22c", out_pc); end
    flush = 1'b1;
    set_ret(1'b1, 32'h900, 5'd4, 1'b1, 32'h9);
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    ret_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fl_ovf got %b exp 0", overflow); end
    checks++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL fl_drop got %0d exp 1", drop_cnt); end
    checks++; if (instret !== 32'd18) begin fails++; $display("FAIL fl_instret got %0d exp 18", instret); end
    set_ret(1'b1, 32'hA00, 5'd1, 1'b1, 32'hA);
    step();
    set_ret(1'b1, 32'hA04, 5'd2, 1'b1, 32'hB);
    step();
    ret_valid = 1'b0;
    checks++; if (out_pc !== 32'hA00) begin fails++; $display("FAIL fl_repush_head got %h exp a00", out_pc); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid got %b exp 0", out_valid); end
    checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL rst_async_drop got %0d exp 0", drop_cnt); end
    checks++; if (instret !== 32'd0) begin fails++; $display("FAIL rst_async_instret got %0d exp 0", instret); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL rst_async_pc got %h exp 0", out_pc); end
    #1;
    rst_n = 1'b1;
    step();
    set_ret(1'b1, 32'hB00, 5'd5, 1'b0, 32'hC);
    step();
    ret_valid = 1'b0;
    checks++; if (out_pc !== 32'hB00) begin fails++; $display("FAIL post_rst_head got %h exp b00", out_pc); end
    checks++; if (instret !== 32'd1) begin fails++; $display("FAIL post_rst_instret got %0d exp 1", instret); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_drain got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
